// File: rtl/if_hazard_ctrl_pkg.sv
// Shared types and widths for the IF-stage hazard controller.
// Holds the controller state encoding and the default datapath widths.
package hazard_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int REG_W_DEF   = 5;
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BR_FLUSH  = 2'd1,
    IMEM_WAIT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/if_hazard_ctrl_load_use_detect.sv
// Load-use comparator between the load in EX and the source registers of the ID instruction.
// Purely combinational, zero latency; x0 as a destination never reports a hazard.
module load_use_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/if_hazard_ctrl.sv
// Sequences IFStage: load-use stalls, EX branch redirects with ID/EX flush, imem wait stalls.
// Redirect/flush one cycle after the request edge; stalls are same-cycle. HAZARD_PERF_CNT_EN adds perf counters.
module if_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int REG_W        = REG_W_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_WAIT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] idRs1,
  input  logic [REG_W-1:0] idRs2,
  input  logic             idUsesRs1,
  input  logic             idUsesRs2,
  input  logic [REG_W-1:0] exRd,
  input  logic             exMemRead,
  input  logic             exBrValid,
  input  logic             exBrTaken,
  input  logic [XLEN-1:0]  exBrOffset,
  input  logic             imemReady,
  output logic             freeze,
  output logic             brTaken,
  output logic [XLEN-1:0]  brOffset,
  output logic             flushId,
  output logic             flushEx,
  output logic             imemTimeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stallCycles,
  output logic [31:0]      flushEvents
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  ctrl_state_t            state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [WAIT_W-1:0]      wait_cnt;

  logic load_use;
  logic br_req;
  logic in_run;
  logic in_wait;
  logic lu_stall;
  logic imem_stall;

  load_use_detect #(
    .REG_W(REG_W)
  ) u_load_use_detect (
    .id_rs1      (idRs1),
    .id_rs2      (idRs2),
    .id_uses_rs1 (idUsesRs1),
    .id_uses_rs2 (idUsesRs2),
    .ex_rd       (exRd),
    .ex_mem_read (exMemRead),
    .load_use    (load_use)
  );

  assign br_req  = exBrValid && exBrTaken;
  assign in_run  = (state == RUN);
  assign in_wait = (state == IMEM_WAIT);

  // The IF/ID contents are flushed during BR_FLUSH, so no stall source is honoured there.
  assign lu_stall   = in_run && load_use && !br_req;
  assign imem_stall = !imemReady && !br_req && ((in_run && !load_use) || in_wait);

  // Gated by rst so stray inputs cannot leak onto the combinational outputs during reset.
  assign freeze  = rst && (lu_stall || imem_stall);
  assign flushEx = rst && (flushId || lu_stall);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      flush_cnt   <= '0;
      wait_cnt    <= '0;
      brTaken     <= 1'b0;
      brOffset    <= '0;
      flushId     <= 1'b0;
      imemTimeout <= 1'b0;
    end else begin
      brTaken <= 1'b0;
      case (state)
        RUN: begin
          if (br_req) begin
            state     <= BR_FLUSH;
            brTaken   <= 1'b1;
            brOffset  <= exBrOffset;
            flushId   <= 1'b1;
            flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          end else if (!load_use && !imemReady) begin
            state    <= IMEM_WAIT;
            wait_cnt <= WAIT_W'(1);
            if (MAX_WAIT == 1) imemTimeout <= 1'b1;
          end
        end
        BR_FLUSH: begin
          if (flush_cnt == '0) begin
            state   <= RUN;
            flushId <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        IMEM_WAIT: begin
          if (br_req) begin
            state     <= BR_FLUSH;
            brTaken   <= 1'b1;
            brOffset  <= exBrOffset;
            flushId   <= 1'b1;
            flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            wait_cnt  <= '0;
          end else if (imemReady) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) imemTimeout <= 1'b1;
          end
        end
        default: begin
          state     <= RUN;
          flushId   <= 1'b0;
          flush_cnt <= '0;
          wait_cnt  <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCycles <= '0;
      flushEvents <= '0;
    end else begin
      if (freeze)  stallCycles <= stallCycles + 32'd1;
      if (brTaken) flushEvents <= flushEvents + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_hazard_ctrl.sv
// Bench for if_hazard_ctrl: directed scenarios then random traffic against a cycle-level reference model.
module tb_if_hazard_ctrl;

  localparam int XLEN = 32;
  localparam int REG_W = 5;
  localparam int FC = 2;
  localparam int MW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [REG_W-1:0] idRs1, idRs2, exRd;
  logic             idUsesRs1, idUsesRs2, exMemRead, exBrValid, exBrTaken, imemReady;
  logic [XLEN-1:0]  exBrOffset;
  logic             freeze, brTaken, flushId, flushEx, imemTimeout;
  logic [XLEN-1:0]  brOffset;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      stallCycles, flushEvents;
  int               m_stall, m_flush;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: remaining flush cycles, consecutive not-ready cycles, sticky flags.
  int          flush_left, wait_run;
  bit          waiting, m_to, m_bt;
  logic [31:0] m_off;

  if_hazard_ctrl #(
    .XLEN(XLEN), .REG_W(REG_W), .FLUSH_CYCLES(FC), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .exRd(exRd), .exMemRead(exMemRead), .exBrValid(exBrValid), .exBrTaken(exBrTaken),
    .exBrOffset(exBrOffset), .imemReady(imemReady),
    .freeze(freeze), .brTaken(brTaken), .brOffset(brOffset),
    .flushId(flushId), .flushEx(flushEx), .imemTimeout(imemTimeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCycles(stallCycles), .flushEvents(flushEvents)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    flush_left = 0; wait_run = 0; waiting = 0; m_to = 0; m_bt = 0; m_off = '0;
`ifdef HAZARD_PERF_CNT_EN
    m_stall = 0; m_flush = 0;
`endif
  endtask

  task automatic idle();
    idRs1 = '0; idRs2 = '0; exRd = '0; idUsesRs1 = 0; idUsesRs2 = 0; exMemRead = 0;
    exBrValid = 0; exBrTaken = 0; exBrOffset = '0; imemReady = 1;
  endtask

  task automatic rand_inputs();
    idRs1 = REG_W'($urandom_range(0, 7)); idRs2 = REG_W'($urandom_range(0, 7));
    exRd = REG_W'($urandom_range(0, 7));
    idUsesRs1 = 1'($urandom); idUsesRs2 = 1'($urandom); exMemRead = 1'($urandom);
    exBrValid = ($urandom_range(0, 4) == 0); exBrTaken = 1'($urandom);
    exBrOffset = $urandom; imemReady = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_freeze"}, freeze, 1'b0);
    chk1({tag, "_brTaken"}, brTaken, 1'b0);
    chk32({tag, "_brOffset"}, brOffset, 32'h0);
    chk1({tag, "_flushId"}, flushId, 1'b0);
    chk1({tag, "_flushEx"}, flushEx, 1'b0);
    chk1({tag, "_timeout"}, imemTimeout, 1'b0);
  endtask

  // One clock: compare every output mid-cycle against the model, then advance the model at the edge.
  task automatic step();
    bit br, lu, inf, lu_eff, st_im;
    @(negedge clk);
    br  = exBrValid && exBrTaken;
    lu  = exMemRead && (exRd != 0) && ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
    inf = (flush_left > 0);
    lu_eff = !inf && !waiting && lu && !br;
    st_im  = !inf && !imemReady && !br && (waiting || !lu);
    chk1("m_freeze", freeze, lu_eff || st_im);
    chk1("m_flushId", flushId, inf);
    chk1("m_flushEx", flushEx, inf || lu_eff);
    chk1("m_brTaken", brTaken, m_bt);
    chk32("m_brOffset", brOffset, m_off);
    chk1("m_timeout", imemTimeout, m_to);
    @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
    if (lu_eff || st_im) m_stall++;
    if (m_bt) m_flush++;
`endif
    m_bt = !inf && br;
    if (m_bt) begin
      m_off = exBrOffset; flush_left = FC; waiting = 0; wait_run = 0;
    end else if (inf) begin
      flush_left--;
    end else if (st_im) begin
      waiting = 1;
      if (wait_run < MW) wait_run++;
      if (wait_run == MW) m_to = 1;
    end else begin
      waiting = 0; wait_run = 0;
    end
    #1;
  endtask

  initial begin
    model_reset();
    // Reset held with random inputs: every output must stay low.
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      #2;
      check_zero("rst_hold");
      @(posedge clk); #1;
    end
    idle();
    rst = 1'b1;
    #1;
    check_zero("rst_rel");
    step();

    // Load-use on rs1: same-cycle freeze and EX bubble.
    exMemRead = 1; exRd = 5; idUsesRs1 = 1; idRs1 = 5;
    #1;
    chk1("lu_freeze", freeze, 1'b1);
    chk1("lu_flushEx", flushEx, 1'b1);
    step();
    idle(); #1;
    chk1("lu_release", freeze, 1'b0);
    chk1("lu_no_br", brTaken, 1'b0);
    step();

    // Load targeting x0 must not stall.
    exMemRead = 1; exRd = 0; idUsesRs1 = 1; idRs1 = 0;
    #1;
    chk1("lu_x0_freeze", freeze, 1'b0);
    step();

    // Taken branch: redirect next cycle, two flush cycles.
    idle(); exBrValid = 1; exBrTaken = 1; exBrOffset = 32'h0000_0010;
    step();
    idle(); #1;
    chk1("br_pulse", brTaken, 1'b1);
    chk32("br_offset", brOffset, 32'h0000_0010);
    chk1("br_flushId1", flushId, 1'b1);
    chk1("br_flushEx1", flushEx, 1'b1);
    step(); #1;
    chk1("br_pulse_end", brTaken, 1'b0);
    chk1("br_flushId2", flushId, 1'b1);
    step(); #1;
    chk1("br_flushId3", flushId, 1'b0);
    chk1("br_flushEx3", flushEx, 1'b0);
    step();

    // Branch and load-use together: branch wins.
    exBrValid = 1; exBrTaken = 1; exBrOffset = 32'hFFFF_FFF8;
    exMemRead = 1; exRd = 3; idUsesRs2 = 1; idRs2 = 3;
    #1;
    chk1("prio_freeze", freeze, 1'b0);
    step();
    idle(); #1;
    chk1("prio_pulse", brTaken, 1'b1);
    chk32("prio_offset", brOffset, 32'hFFFF_FFF8);
    for (int i = 0; i < 3; i++) step();

    // Three imem wait cycles then ready.
    imemReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1; chk1("imem_freeze", freeze, 1'b1);
      step();
    end
    imemReady = 1; #1;
    chk1("imem_release", freeze, 1'b0);
    step(); step();

    // Six wait cycles with MAX_WAIT=4: timeout visible once four wait cycles have elapsed.
    chk1("to_pre", imemTimeout, 1'b0);
    imemReady = 0;
    for (int k = 1; k <= 6; k++) begin
      #1; chk1("to_rise", imemTimeout, k > MW);
      step();
    end
    imemReady = 1;
    step(); step(); #1;
    chk1("to_sticky", imemTimeout, 1'b1);

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end

    // Reset during the second flush cycle aborts everything, no leftovers after release.
    idle(); step();
    exBrValid = 1; exBrTaken = 1; exBrOffset = 32'h0000_0040;
    step();
    idle(); step();
    chk1("mid_flushId", flushId, 1'b1);
    #1 rst = 1'b0;
    #1 check_zero("mid_rst");
    model_reset();
    @(posedge clk); #1;
    check_zero("mid_hold");
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("post_brTaken", brTaken, 1'b0);
      chk1("post_flushId", flushId, 1'b0);
    end

`ifdef HAZARD_PERF_CNT_EN
    chk32("perf_stall", stallCycles, 32'(m_stall));
    chk32("perf_flush", flushEvents, 32'(m_flush));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_hazard_ctrl.md
Name: if_hazard_ctrl

Overview:
- Pipeline control unit that sequences IFStage.
- Generates IFStage's freeze, brTaken and brOffset inputs, plus flush strobes for the ID and EX pipeline registers.
- Resolves three event types:
  - load-use hazards;
  - taken branches resolved in EX;
  - instruction-memory wait states.
- Sits between IFStage, the ID/EX pipeline registers and the instruction memory.

Parameters:
- XLEN, 32, width of PC/offset datapath.
- REG_W, 5, register-index width.
- FLUSH_CYCLES, 2, cycles flushId/flushEx stay high after a taken branch (1..7).
- MAX_WAIT, 255, imem wait cycles before timeout flag (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- idRs1  in  REG_W  rs1 index of the instruction in ID.
- idRs2  in  REG_W  rs2 index of the instruction in ID.
- idUsesRs1  in  1  ID instruction reads rs1.
- idUsesRs2  in  1  ID instruction reads rs2.
- exRd  in  REG_W  destination of the instruction in EX.
- exMemRead  in  1  EX instruction is a load.
- exBrValid  in  1  branch resolved in EX this cycle.
- exBrTaken  in  1  resolved branch is taken.
- exBrOffset  in  XLEN  branch offset from EX.
- imemReady  in  1  instruction memory has valid data this cycle.
- freeze  out  1  hold PC and IF/ID register.
- brTaken  out  1  one-cycle redirect pulse to IFStage.
- brOffset  out  XLEN  redirect offset, valid while brTaken=1.
- flushId  out  1  bubble IF/ID register.
- flushEx  out  1  bubble ID/EX register.
- imemTimeout  out  1  sticky: imem wait exceeded MAX_WAIT.

Behaviour:
- Reset (rst=0, async):
  - state=RUN.
  - All outputs 0; brOffset=0.
  - Counters cleared.
  - Reset asserted mid-flush or mid-wait aborts immediately, with no residual pulses after release.
- States:
  - RUN, BR_FLUSH, IMEM_WAIT in a 2-bit enum.
  - Registered state, one-hot-safe default returns to RUN.
- loadUse (combinational) = exMemRead & exRd!=0 & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd)).
- brReq = exBrValid & exBrTaken. Priority, highest first: brReq > loadUse > imem wait.
- RUN state:
  - brReq:
    - Next cycle brTaken=1 for exactly one cycle, with brOffset=exBrOffset latched at the request edge.
    - flushId=flushEx=1 for FLUSH_CYCLES cycles starting that same cycle.
    - Go to BR_FLUSH.
  - else loadUse:
    - freeze=1 and flushEx=1 combinationally in the same cycle.
    - Stays in RUN; the stall lasts while loadUse holds, normally 1 cycle.
  - else imemReady=0:
    - freeze=1 combinationally.
    - Go to IMEM_WAIT; wait counter=1.
- BR_FLUSH state:
  - Flush down-counter decrements each cycle; return to RUN when it reaches 0.
  - A new brReq during BR_FLUSH is ignored, because EX is flushed.
  - loadUse is ignored while in BR_FLUSH.
- IMEM_WAIT state:
  - freeze=1.
  - imemReady=1: return to RUN next cycle; freeze drops in that cycle.
  - Wait counter saturates at MAX_WAIT; on reaching it, set imemTimeout (sticky until reset) and keep waiting.
  - brReq in IMEM_WAIT: emit the redirect as in RUN, go to BR_FLUSH, and clear the wait counter.
- Outputs:
  - brTaken, brOffset, flushId and imemTimeout are registered.
  - freeze and flushEx are OR of registered state terms and the combinational loadUse term.
- brOffset holds its last value when brTaken=0 (don't-care to IFStage).
- exRd=0 never causes a stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds output ports stallCycles (32-bit, counts cycles with freeze=1) and flushEvents (32-bit, counts brTaken pulses). Both wrap at 2^32 and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package hazard_pkg holds:
  - ctrl_state_t enum {RUN, BR_FLUSH, IMEM_WAIT};
  - localparams XLEN_DEF=32 and REG_W_DEF=5;
  - the FLUSH_CNT_W width constant.
- One natural sub-module, load_use_detect: purely combinational comparator producing loadUse. if_hazard_ctrl instantiates it alongside the FSM and counters.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0. Release rst -> freeze=0, brTaken=0, state RUN.
- Load-use: exMemRead=1, exRd=5, idUsesRs1=1, idRs1=5 for one cycle -> freeze=1 and flushEx=1 that cycle only, brTaken=0. Same with exRd=0 -> no stall.
- Taken branch: exBrValid=1, exBrTaken=1, exBrOffset=32'h0000_0010 -> next cycle brTaken=1, brOffset=0x10. flushId=flushEx=1 for exactly 2 cycles, then RUN.
- Priority: brReq and loadUse in the same cycle -> redirect and flush occur; no load-use freeze.
- Imem wait: imemReady=0 for 3 cycles then 1 -> freeze=1 for 3 cycles, drops when ready. With MAX_WAIT=4 and ready low for 6 cycles -> imemTimeout rises on the 4th wait cycle and stays set.
- Mid-operation reset: assert rst=0 during the 2nd BR_FLUSH cycle -> flush outputs drop asynchronously; after release, no further brTaken/flush pulses.
